// File: rtl/reg_file_multi.sv
// Multi-port register file: NRD combinational read ports and two write ports (B over A).
// Also provides optional write-to-read bypass, a hardwired-zero r0 and a pending-write scoreboard.
module reg_file_multi #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  reg_file_multi_clk,
    input  logic                  reg_file_multi_rst,
    input  logic [NRD*ADDR_W-1:0] reg_file_multi_rd_addr,
    output logic [NRD*DATA_W-1:0] reg_file_multi_rd_data,
    output logic [NRD-1:0]        reg_file_multi_rd_busy,
    input  logic                  reg_file_multi_wa_en,
    input  logic [ADDR_W-1:0]     reg_file_multi_wa_addr,
    input  logic [DATA_W-1:0]     reg_file_multi_wa_data,
    input  logic                  reg_file_multi_wb_en,
    input  logic [ADDR_W-1:0]     reg_file_multi_wb_addr,
    input  logic [DATA_W-1:0]     reg_file_multi_wb_data,
    input  logic                  reg_file_multi_rsv_en,
    input  logic [ADDR_W-1:0]     reg_file_multi_rsv_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit Z0    = (ZERO_R0 != 0);
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              wa_ok;
    logic              wb_ok;

    assign wa_ok = reg_file_multi_wa_en && !(Z0 && (reg_file_multi_wa_addr == '0));
    assign wb_ok = reg_file_multi_wb_en && !(Z0 && (reg_file_multi_wb_addr == '0));

    // Reservation is applied after the clears so a same-cycle write cannot retire a newer producer.
    always_comb begin
        pending_nxt = pending;
        if (reg_file_multi_wa_en) begin
            pending_nxt[reg_file_multi_wa_addr] = 1'b0;
        end
        if (reg_file_multi_wb_en) begin
            pending_nxt[reg_file_multi_wb_addr] = 1'b0;
        end
        if (reg_file_multi_rsv_en) begin
            pending_nxt[reg_file_multi_rsv_addr] = 1'b1;
        end
        if (Z0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    // Port B is assigned last so it wins a same-address collision.
    always_ff @(posedge reg_file_multi_clk) begin
        if (reg_file_multi_rst) begin
            pending <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            if (wa_ok) begin
                mem[reg_file_multi_wa_addr] <= reg_file_multi_wa_data;
            end
            if (wb_ok) begin
                mem[reg_file_multi_wb_addr] <= reg_file_multi_wb_data;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              hit_a;
        logic              hit_b;

        assign addr  = reg_file_multi_rd_addr[g*ADDR_W +: ADDR_W];
        assign hit_a = BYP && reg_file_multi_wa_en && (reg_file_multi_wa_addr == addr);
        assign hit_b = BYP && reg_file_multi_wb_en && (reg_file_multi_wb_addr == addr);

        always_comb begin
            data = mem[addr];
            busy = pending[addr];
            if (hit_b) begin
                data = reg_file_multi_wb_data;
            end else if (hit_a) begin
                data = reg_file_multi_wa_data;
            end
            if (hit_a || hit_b) begin
                busy = 1'b0;
            end
            if (Z0 && (addr == '0)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign reg_file_multi_rd_data[g*DATA_W +: DATA_W] = data;
        assign reg_file_multi_rd_busy[g]                  = busy;
    end

endmodule

// File: tb/tb_reg_file_multi.sv
// Bench for reg_file_multi: default, no-bypass and wide/four-port instances,
// table vectors, hand sequences and random traffic against a reference array.
module tb_reg_file_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance: DATA_W=32 ADDR_W=5 NRD=2 ZERO_R0=1 BYPASS=1
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en, wb_en, rsv_en;
    logic [4:0]  wa_addr, wb_addr, rsv_addr;
    logic [31:0] wa_data, wb_data;

    // BYPASS=0 instance
    logic        n_rst;
    logic [9:0]  n_rd_addr;
    logic [63:0] n_rd_data;
    logic [1:0]  n_rd_busy;
    logic        n_wa_en, n_wb_en, n_rsv_en;
    logic [4:0]  n_wa_addr, n_wb_addr, n_rsv_addr;
    logic [31:0] n_wa_data, n_wb_data;

    // wide instance: DATA_W=64 ADDR_W=6 NRD=4
    logic         w_rst;
    logic [23:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_wa_en, w_wb_en, w_rsv_en;
    logic [5:0]   w_wa_addr, w_wb_addr, w_rsv_addr;
    logic [63:0]  w_wa_data, w_wb_data;

    reg_file_multi u_dut (
        .reg_file_multi_clk(clk), .reg_file_multi_rst(rst),
        .reg_file_multi_rd_addr(rd_addr), .reg_file_multi_rd_data(rd_data),
        .reg_file_multi_rd_busy(rd_busy),
        .reg_file_multi_wa_en(wa_en), .reg_file_multi_wa_addr(wa_addr),
        .reg_file_multi_wa_data(wa_data),
        .reg_file_multi_wb_en(wb_en), .reg_file_multi_wb_addr(wb_addr),
        .reg_file_multi_wb_data(wb_data),
        .reg_file_multi_rsv_en(rsv_en), .reg_file_multi_rsv_addr(rsv_addr)
    );

    reg_file_multi #(.BYPASS(0)) u_nb (
        .reg_file_multi_clk(clk), .reg_file_multi_rst(n_rst),
        .reg_file_multi_rd_addr(n_rd_addr), .reg_file_multi_rd_data(n_rd_data),
        .reg_file_multi_rd_busy(n_rd_busy),
        .reg_file_multi_wa_en(n_wa_en), .reg_file_multi_wa_addr(n_wa_addr),
        .reg_file_multi_wa_data(n_wa_data),
        .reg_file_multi_wb_en(n_wb_en), .reg_file_multi_wb_addr(n_wb_addr),
        .reg_file_multi_wb_data(n_wb_data),
        .reg_file_multi_rsv_en(n_rsv_en), .reg_file_multi_rsv_addr(n_rsv_addr)
    );

    reg_file_multi #(.DATA_W(64), .ADDR_W(6), .NRD(4)) u_wide (
        .reg_file_multi_clk(clk), .reg_file_multi_rst(w_rst),
        .reg_file_multi_rd_addr(w_rd_addr), .reg_file_multi_rd_data(w_rd_data),
        .reg_file_multi_rd_busy(w_rd_busy),
        .reg_file_multi_wa_en(w_wa_en), .reg_file_multi_wa_addr(w_wa_addr),
        .reg_file_multi_wa_data(w_wa_data),
        .reg_file_multi_wb_en(w_wb_en), .reg_file_multi_wb_addr(w_wb_addr),
        .reg_file_multi_wb_data(w_wb_data),
        .reg_file_multi_rsv_en(w_rsv_en), .reg_file_multi_rsv_addr(w_rsv_addr)
    );

    typedef struct {
        logic        rst;
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r,
                                input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                                input logic be, input logic [4:0] ba, input logic [31:0] bd,
                                input logic re, input logic [4:0] ra,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] d0, input logic b0,
                                input logic [31:0] d1, input logic b1);
        vec_t v;
        v.rst = r;  v.wa_en = ae; v.wa_addr = aa; v.wa_data = ad;
        v.wb_en = be; v.wb_addr = ba; v.wb_data = bd;
        v.rsv_en = re; v.rsv_addr = ra;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [63:0] mdl [64];
    logic [5:0]  ra;
    logic [63:0] ed;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_addr = '0; wa_en = 0; wb_en = 0; rsv_en = 0;
        wa_addr = '0; wb_addr = '0; rsv_addr = '0; wa_data = '0; wb_data = '0;
        n_rst = 1'b1; n_rd_addr = '0; n_wa_en = 0; n_wb_en = 0; n_rsv_en = 0;
        n_wa_addr = '0; n_wb_addr = '0; n_rsv_addr = '0; n_wa_data = '0; n_wb_data = '0;
        w_rst = 1'b1; w_rd_addr = '0; w_wa_en = 0; w_wb_en = 0; w_rsv_en = 0;
        w_wa_addr = '0; w_wb_addr = '0; w_rsv_addr = '0; w_wa_data = '0; w_wb_data = '0;

        //                rst  wa             wb              rsv    a0  a1   d0        b0  d1        b1
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  5,  0,  0,        0, 0,        0));
        vecs.push_back(mk(0, 1, 5, 'h1234,   0, 0, 0,        0, 0,  5,  6,  'h1234,   0, 0,        0));
        vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,        0, 0,  5,  5,  'h1234,   0, 'h1234,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  5,  0,  0,        0, 0,        0));
        vecs.push_back(mk(0, 1, 0, 'hFFFF,   0, 0, 0,        1, 0,  0,  0,  0,        0, 0,        0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  0,  0,  0,        0, 0,        0));
        vecs.push_back(mk(0, 1, 7, 'hAAAA,   1, 7, 'h5555,   0, 0,  7,  7,  'h5555,   0, 'h5555,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  7,  8,  'h5555,   0, 0,        0));
        vecs.push_back(mk(0, 1, 3, 'hDEAD,   0, 0, 0,        0, 0,  8,  3,  0,        0, 'hDEAD,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        1, 9,  9,  3,  0,        0, 'hDEAD,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  9,  9,  0,        1, 0,        1));
        vecs.push_back(mk(0, 0, 0, 0,        1, 10, 'h11,    0, 0,  9,  10, 0,        1, 'h11,     0));
        vecs.push_back(mk(0, 1, 9, 'hBEEF,   0, 0, 0,        0, 0,  9,  9,  'hBEEF,   0, 'hBEEF,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  9,  10, 'hBEEF,   0, 'h11,     0));
        vecs.push_back(mk(0, 1, 9, 'hC0DE,   0, 0, 0,        1, 9,  9,  9,  'hC0DE,   0, 'hC0DE,   0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  9,  9,  'hC0DE,   1, 'hC0DE,   1));
        vecs.push_back(mk(0, 0, 0, 0,        1, 9, 'h77,     0, 0,  9,  9,  'h77,     0, 'h77,     0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  9,  9,  'h77,     0, 'h77,     0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        1, 12, 12, 9,  0,        0, 'h77,     0));
        vecs.push_back(mk(0, 1, 12, 'h5,     0, 0, 0,        1, 13, 12, 13, 'h5,      0, 0,        0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  12, 13, 'h5,      0, 0,        1));
        vecs.push_back(mk(1, 1, 14, 'h99,    0, 0, 0,        1, 14, 13, 14, 0,        1, 'h99,     0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  13, 14, 0,        0, 0,        0));
        vecs.push_back(mk(0, 1, 20, 'h1,     1, 21, 'h2,     0, 0,  21, 20, 'h2,      0, 'h1,      0));
        vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0,  20, 21, 'h1,      0, 'h2,      0));
        vecs.push_back(mk(0, 0, 0, 0,        1, 0, 'h1,      0, 0,  0,  21, 0,        0, 'h2,      0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        w_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
            rd_addr = {vecs[i].a1, vecs[i].a0};
            #4;
            chk($sformatf("v%0d data0", i), 64'(rd_data[31:0]),  64'(vecs[i].d0));
            chk($sformatf("v%0d data1", i), 64'(rd_data[63:32]), 64'(vecs[i].d1));
            chk($sformatf("v%0d busy0", i), 64'(rd_busy[0]),     64'(vecs[i].b0));
            chk($sformatf("v%0d busy1", i), 64'(rd_busy[1]),     64'(vecs[i].b1));
        end
        @(negedge clk);
        rst = 1'b0; wa_en = 0; wb_en = 0; rsv_en = 0;

        // no-bypass instance: write visible only after the edge, busy ignores same-cycle write
        n_wa_en = 1; n_wa_addr = 3; n_wa_data = 'hDEAD; n_rd_addr = {5'd3, 5'd4};
        #4;
        chk("nb same-cycle old data", 64'(n_rd_data[63:32]), 64'h0);
        @(negedge clk);
        n_wa_en = 0; n_rsv_en = 1; n_rsv_addr = 4;
        #4;
        chk("nb data after edge", 64'(n_rd_data[63:32]), 64'hDEAD);
        chk("nb busy before rsv edge", 64'(n_rd_busy[0]), 64'h0);
        @(negedge clk);
        n_rsv_en = 0; n_wa_en = 1; n_wa_addr = 4; n_wa_data = 'h1;
        #4;
        chk("nb busy during write", 64'(n_rd_busy[0]), 64'h1);
        chk("nb data during write", 64'(n_rd_data[31:0]), 64'h0);
        @(negedge clk);
        n_wa_en = 0;
        #4;
        chk("nb busy after write", 64'(n_rd_busy[0]), 64'h0);
        chk("nb data after write", 64'(n_rd_data[31:0]), 64'h1);

        // wide instance: r63 on all four ports, same cycle (bypass) and next cycle (array)
        @(negedge clk);
        w_wb_en = 1; w_wb_addr = 63; w_wb_data = 64'h0123456789ABCDEF;
        w_rd_addr = {6'd63, 6'd63, 6'd63, 6'd63};
        #4;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("wide bypass r63 p%0d", p), w_rd_data[p*64 +: 64], 64'h0123456789ABCDEF);
        end
        @(negedge clk);
        w_wb_en = 0;
        #4;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("wide r63 p%0d", p), w_rd_data[p*64 +: 64], 64'h0123456789ABCDEF);
        end

        for (int k = 0; k < 64; k++) mdl[k] = '0;
        mdl[63] = 64'h0123456789ABCDEF;

        // random traffic against the reference array, addresses biased low to force collisions
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            w_wa_en   = 1'($urandom_range(0, 1));
            w_wa_addr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            w_wa_data = {$urandom, $urandom};
            w_wb_en   = 1'($urandom_range(0, 1));
            w_wb_addr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            w_wb_data = {$urandom, $urandom};
            for (int p = 0; p < 4; p++) begin
                w_rd_addr[p*6 +: 6] = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7))
                                                                  : 6'($urandom_range(0, 63));
            end
            #4;
            for (int p = 0; p < 4; p++) begin
                ra = w_rd_addr[p*6 +: 6];
                if (ra == 0)                          ed = '0;
                else if (w_wb_en && w_wb_addr == ra)  ed = w_wb_data;
                else if (w_wa_en && w_wa_addr == ra)  ed = w_wa_data;
                else                                  ed = mdl[ra];
                chk($sformatf("rand c%0d p%0d data", c, p), w_rd_data[p*64 +: 64], ed);
                chk($sformatf("rand c%0d p%0d busy", c, p), 64'(w_rd_busy[p]), 64'h0);
            end
            if (w_wa_en && w_wa_addr != 0) mdl[w_wa_addr] = w_wa_data;
            if (w_wb_en && w_wb_addr != 0) mdl[w_wb_addr] = w_wb_data;
        end
        @(negedge clk);
        w_wa_en = 0;
        w_wb_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_multi.md
# reg_file_multi

Parametrised multi-port register file for the MIPS datapath. It provides NRD combinational read ports and two write ports with fixed priority. It adds optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending-write scoreboard that the decode stage uses for hazard detection. It sits between decode (reads, reservations) and writeback (port A: ALU result; port B: load/late result).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: a read of an address being written this cycle returns the write data

Ports (one clock; reset is synchronous and active-high):
- reg_file_multi_clk  in  1  clock; all state updates on rising edge
- reg_file_multi_rst  in  1  synchronous active-high reset
- reg_file_multi_rd_addr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- reg_file_multi_rd_data  out  NRD*DATA_W  read data, combinational
- reg_file_multi_rd_busy  out  NRD  1 = addressed register has a pending write
- reg_file_multi_wa_en / _wa_addr / _wa_data  in  1 / ADDR_W / DATA_W  write port A
- reg_file_multi_wb_en / _wb_addr / _wb_data  in  1 / ADDR_W / DATA_W  write port B
- reg_file_multi_rsv_en  in  1  mark register as pending write
- reg_file_multi_rsv_addr  in  ADDR_W  register to reserve

## Operation
- Storage: 2**ADDR_W x DATA_W array, plus a pending bit per register.
- Write: on a rising edge with wa_en, array[wa_addr] <= wa_data. wb_en works the same way.
  - Both ports enabled to the same address: port B wins; port A is discarded.
  - ZERO_R0=1: writes to address 0 are dropped.
- Pending bits are evaluated in this order each edge:
  - clear pending[wa_addr] if wa_en;
  - clear pending[wb_addr] if wb_en;
  - then set pending[rsv_addr] if rsv_en.
  - A reservation and a write to the same address in the same cycle leave the bit set (newer producer outstanding).
  - ZERO_R0=1: pending[0] is never set.
  - Writing a register that is not pending is legal and leaves the bit clear.
- Read port i data:
  - ZERO_R0=1 and addr 0 -> 0.
  - Else, if BYPASS=1 and wb_en and wb_addr==addr -> wb_data.
  - Else, if BYPASS=1 and wa_en and wa_addr==addr -> wa_data.
  - Else -> array[addr].
- Read port i busy:
  - BYPASS=1: pending[addr], but forced 0 when a write to addr is present this cycle.
  - BYPASS=0: pending[addr] only.
  - Always 0 for addr 0 when ZERO_R0=1.
- Reset: on an edge with rst high, every array entry and every pending bit clears to 0. Writes and reservations in that cycle are ignored.
  - A reset issued with writes or reservations in flight discards them.
- Read addresses equal on several ports: each port returns identical data and busy.

## Timing
- Read latency 0: rd_data and rd_busy are combinational from rd_addr, array state, pending state, and (BYPASS=1) the current write ports.
- Write latency: the new value is visible via the array one edge after en is sampled; it is visible in the same cycle when BYPASS=1.
- Reservation latency: rd_busy rises the cycle after the rsv_en edge.
- Reset values after the reset edge: all rd_data = 0, all rd_busy = 0.
- No combinational path from rsv_* to any output.
- Throughput: both write ports and one reservation accepted every cycle; no stalls, no backpressure.

## Test plan
- Reset/zero: preload r5=0x1234, assert rst one cycle -> rd_addr0=5 gives data 0, busy 0. Write r0=0xFFFF -> read r0 = 0.
- Dual write conflict: wa_en=wb_en=1, both addr 7, wa_data=0xAAAA, wb_data=0x5555 -> next cycle r7 = 0x5555. With BYPASS=1, same-cycle read of r7 already returns 0x5555.
- Bypass: BYPASS=1, write r3=0xDEAD while port 1 reads r3 -> rd_data1=0xDEAD that cycle. BYPASS=0 -> old value that cycle, 0xDEAD the next.
- Scoreboard: rsv r9 at cycle n -> busy=1 from n+1. wa write r9 at cycle n+3 -> busy=0 (BYPASS=1) in cycle n+3, data correct. Busy stays 0 afterwards.
- Simultaneous rsv and write to r9 -> pending stays 1; the subsequent write clears it.
- Parameter sweep: NRD=4, DATA_W=64, ADDR_W=6 -> write r63=0x0123456789ABCDEF, read on all four ports -> identical data. Random write/read traffic is checked against a reference-model array.
